// File: rtl/udp_rx_noc_msg_builder_if.sv
`default_nettype none
// ============================================================================
// Module   : udp_rx_noc_msg_builder_if
// Purpose  : Bundles the three handshake channels of the UDP RX NoC message
//            builder: datagram info, payload flit stream and NoC output.
// Ports    : none (interface). Modports:
//              slave  - the message builder's view
//              master - the surrounding environment (upstream + NoC router)
// Revision : 1.0 - initial release
// ============================================================================
interface udp_rx_noc_msg_builder_if #(
  parameter int NOC_DATA_W   = 512,
  parameter int IP_ADDR_W    = 32,
  parameter int PORT_NUM_W   = 16,
  parameter int UDP_LENGTH_W = 16
);
  // datagram info channel
  logic                    info_val;
  logic [IP_ADDR_W-1:0]    info_src_ip;
  logic [IP_ADDR_W-1:0]    info_dst_ip;
  logic [PORT_NUM_W-1:0]   info_src_port;
  logic [PORT_NUM_W-1:0]   info_dst_port;
  logic [UDP_LENGTH_W-1:0] info_data_length;
  logic                    info_rdy;
  // payload flit channel
  logic                    payload_val;
  logic [NOC_DATA_W-1:0]   payload_data;
  logic                    payload_rdy;
  // NoC output channel
  logic                    noc_val;
  logic [NOC_DATA_W-1:0]   noc_data;
  logic                    noc_rdy;

  modport slave (
    input  info_val, info_src_ip, info_dst_ip, info_src_port, info_dst_port,
           info_data_length, payload_val, payload_data, noc_rdy,
    output info_rdy, payload_rdy, noc_val, noc_data
  );

  modport master (
    output info_val, info_src_ip, info_dst_ip, info_src_port, info_dst_port,
           info_data_length, payload_val, payload_data, noc_rdy,
    input  info_rdy, payload_rdy, noc_val, noc_data
  );
endinterface
`default_nettype wire

// File: rtl/udp_rx_noc_msg_builder.sv
`default_nettype none
// ============================================================================
// Module   : udp_rx_noc_msg_builder
// Purpose  : Last stage of the UDP RX path. Turns one parsed datagram (info
//            beat + payload flits) into a NoC message: header flit, metadata
//            flit carrying an RX timestamp, then ceil(len/BYTES) payload flits.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            src_x, src_y        - this tile's coordinates (static)
//            dst_x, dst_y        - destination tile coordinates (static)
//            bus (slave modport) - info, payload and NoC handshake channels
// Revision : 1.0 - initial release
// ============================================================================
module udp_rx_noc_msg_builder #(
  parameter int NOC_DATA_W      = 512,
  parameter int IP_ADDR_W       = 32,
  parameter int PORT_NUM_W      = 16,
  parameter int UDP_LENGTH_W    = 16,
  parameter int MSG_TIMESTAMP_W = 64,
  parameter int XY_W            = 8,
  parameter int MSG_LEN_W       = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [XY_W-1:0] src_x,
  input  wire logic [XY_W-1:0] src_y,
  input  wire logic [XY_W-1:0] dst_x,
  input  wire logic [XY_W-1:0] dst_y,
  udp_rx_noc_msg_builder_if.slave bus
);

  localparam int BYTES      = NOC_DATA_W / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  // one extra bit so a 65535-byte datagram does not overflow the rounding add
  localparam int FLIT_CNT_W = UDP_LENGTH_W + 1;
  localparam int HDR_W      = 4 * XY_W + MSG_LEN_W;
  localparam int META_W     = 2 * IP_ADDR_W + 2 * PORT_NUM_W + UDP_LENGTH_W
                              + MSG_TIMESTAMP_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_META = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  logic [1:0]                 r_state;
  logic [MSG_TIMESTAMP_W-1:0] r_ts_cnt;
  logic [MSG_TIMESTAMP_W-1:0] r_ts;
  logic [IP_ADDR_W-1:0]       r_src_ip;
  logic [IP_ADDR_W-1:0]       r_dst_ip;
  logic [PORT_NUM_W-1:0]      r_src_port;
  logic [PORT_NUM_W-1:0]      r_dst_port;
  logic [UDP_LENGTH_W-1:0]    r_len;
  logic [FLIT_CNT_W-1:0]      r_data_flits;
  logic [FLIT_CNT_W-1:0]      r_flit_cnt;

  logic [FLIT_CNT_W-1:0]      w_data_flits;
  logic [MSG_LEN_W-1:0]       w_msg_len;
  logic [NOC_DATA_W-1:0]      w_hdr;
  logic [NOC_DATA_W-1:0]      w_meta;
  logic                       w_last_flit;

  // ceil(len / BYTES)
  assign w_data_flits = ({1'b0, bus.info_data_length} + FLIT_CNT_W'(BYTES - 1))
                        >> BYTE_SHIFT;

  // message length counts the metadata flit; wider values are truncated
  assign w_msg_len = MSG_LEN_W'(r_data_flits) + MSG_LEN_W'(1);

  assign w_hdr  = {dst_x, dst_y, w_msg_len, src_x, src_y,
                   {(NOC_DATA_W - HDR_W){1'b0}}};
  assign w_meta = {r_src_ip, r_dst_ip, r_src_port, r_dst_port, r_len, r_ts,
                   {(NOC_DATA_W - META_W){1'b0}}};

  assign w_last_flit = ((r_flit_cnt + FLIT_CNT_W'(1)) == r_data_flits);

  // Outputs decode straight from state so an async reset drops noc_val at once.
  always_comb begin
    bus.info_rdy    = 1'b0;
    bus.payload_rdy = 1'b0;
    bus.noc_val     = 1'b0;
    bus.noc_data    = '0;
    case (r_state)
      ST_IDLE: bus.info_rdy = 1'b1;
      ST_HDR: begin
        bus.noc_val  = 1'b1;
        bus.noc_data = w_hdr;
      end
      ST_META: begin
        bus.noc_val  = 1'b1;
        bus.noc_data = w_meta;
      end
      ST_DATA: begin
        bus.noc_val     = bus.payload_val;
        bus.noc_data    = bus.payload_data;
        bus.payload_rdy = bus.noc_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ts_cnt     <= '0;
      r_ts         <= '0;
      r_src_ip     <= '0;
      r_dst_ip     <= '0;
      r_src_port   <= '0;
      r_dst_port   <= '0;
      r_len        <= '0;
      r_data_flits <= '0;
      r_flit_cnt   <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + MSG_TIMESTAMP_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (bus.info_val) begin
            r_src_ip     <= bus.info_src_ip;
            r_dst_ip     <= bus.info_dst_ip;
            r_src_port   <= bus.info_src_port;
            r_dst_port   <= bus.info_dst_port;
            r_len        <= bus.info_data_length;
            r_ts         <= r_ts_cnt;
            r_data_flits <= w_data_flits;
            r_state      <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (bus.noc_rdy) r_state <= ST_META;
        end
        ST_META: begin
          if (bus.noc_rdy) begin
            r_flit_cnt <= '0;
            r_state    <= (r_data_flits != '0) ? ST_DATA : ST_IDLE;
          end
        end
        ST_DATA: begin
          if (bus.payload_val && bus.noc_rdy) begin
            if (w_last_flit) begin
              r_flit_cnt <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_flit_cnt <= r_flit_cnt + FLIT_CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_noc_msg_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_rx_noc_msg_builder
// Purpose  : Self-checking bench for udp_rx_noc_msg_builder. A queue-based
//            model turns every accepted info beat into the expected list of
//            NoC flits; one negedge process compares the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_rx_noc_msg_builder;

  localparam int W     = 512;
  localparam int BYTES = W / 8;
  localparam logic [1:0] K_HDR  = 2'd0;
  localparam logic [1:0] K_META = 2'd1;
  localparam logic [1:0] K_PAY  = 2'd2;

  typedef struct {
    logic [1:0]   kind;
    logic [W-1:0] data;
  } flit_t;

  typedef struct {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
    int          lit_flits;
    bit          pin;
  } info_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src_x = 8'd1;
  logic [7:0] src_y = 8'd2;
  logic [7:0] dst_x = 8'd3;
  logic [7:0] dst_y = 8'd4;

  flit_t        sb_q[$];
  info_t        info_q[$];
  logic [W-1:0] pay_q[$];
  logic [W-1:0] exp_pay_q[$];

  int          total = 0;
  int          bad = 0;
  int          pay_pops = 0;
  int          pay_acc_cnt = 0;
  bit          stall_en = 1'b0;
  logic [63:0] tb_ts;

  udp_rx_noc_msg_builder_if #(.NOC_DATA_W(W)) bus ();

  udp_rx_noc_msg_builder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src_x (src_x),
    .src_y (src_y),
    .dst_x (dst_x),
    .dst_y (dst_y),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // free-running reference timestamp: cycles since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 64'd1;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_flit();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected message for one accepted datagram, built from the field layout.
  task automatic accept_info();
    info_t        f;
    int           flits;
    logic [7:0]   mlen;
    logic [W-1:0] hdr;
    logic [W-1:0] meta;
    f     = info_q.pop_front();
    flits = (int'(f.len) + BYTES - 1) / BYTES;
    mlen  = 8'((1 + flits) % 256);
    hdr   = '0;
    hdr[W-1  -: 8] = dst_x;
    hdr[W-9  -: 8] = dst_y;
    hdr[W-17 -: 8] = mlen;
    hdr[W-25 -: 8] = src_x;
    hdr[W-33 -: 8] = src_y;
    meta  = '0;
    meta[W-1   -: 32] = f.sip;
    meta[W-33  -: 32] = f.dip;
    meta[W-65  -: 16] = f.sp;
    meta[W-81  -: 16] = f.dp;
    meta[W-97  -: 16] = f.len;
    meta[W-113 -: 64] = tb_ts;
    if (f.lit_flits >= 0) chk("model_flit_count", W'(flits), W'(f.lit_flits));
    if (f.pin) begin
      chk("model_hdr_lit", W'(hdr[W-1 -: 40]), W'(40'h03_04_03_01_02));
      chk("model_meta_lit", W'(meta[W-1 -: 112]),
          W'(112'h0A000001_0A000002_1388_0007_0064));
    end
    sb_q.push_back('{K_HDR, hdr});
    sb_q.push_back('{K_META, meta});
    for (int i = 0; i < flits; i++) sb_q.push_back('{K_PAY, exp_pay_q.pop_front()});
  endtask

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_q.size() == 0) begin
        chk("idle_noc_val", W'(bus.noc_val), W'(1'b0));
        chk("idle_info_rdy", W'(bus.info_rdy), W'(1'b1));
        chk("idle_payload_rdy", W'(bus.payload_rdy), W'(1'b0));
      end else begin
        chk("busy_info_rdy", W'(bus.info_rdy), W'(1'b0));
        if (sb_q[0].kind == K_PAY) begin
          chk("data_noc_val", W'(bus.noc_val), W'(bus.payload_val));
          chk("data_payload_rdy", W'(bus.payload_rdy), W'(bus.noc_rdy));
        end else begin
          chk("hdr_meta_noc_val", W'(bus.noc_val), W'(1'b1));
          chk("hdr_meta_payload_rdy", W'(bus.payload_rdy), W'(1'b0));
        end
        if (bus.noc_val) begin
          case (sb_q[0].kind)
            K_HDR:   chk("hdr_flit", bus.noc_data, sb_q[0].data);
            K_META:  chk("meta_flit", bus.noc_data, sb_q[0].data);
            default: chk("data_flit", bus.noc_data, sb_q[0].data);
          endcase
          if (bus.noc_rdy) begin
            if (sb_q[0].kind == K_PAY) pay_pops++;
            void'(sb_q.pop_front());
          end
        end
      end
      if (bus.payload_val && bus.payload_rdy) begin
        void'(pay_q.pop_front());
        pay_acc_cnt++;
      end
      if (bus.info_val && bus.info_rdy) accept_info();
    end else begin
      sb_q.delete();
      info_q.delete();
      pay_q.delete();
      exp_pay_q.delete();
    end
  end

  // input driver: info and payload from queues, random NoC back-pressure
  initial begin
    int seen_acc;
    seen_acc             = 0;
    bus.info_val         = 1'b0;
    bus.info_src_ip      = '0;
    bus.info_dst_ip      = '0;
    bus.info_src_port    = '0;
    bus.info_dst_port    = '0;
    bus.info_data_length = '0;
    bus.payload_val      = 1'b0;
    bus.payload_data     = '0;
    bus.noc_rdy          = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.noc_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (info_q.size() != 0) begin
        bus.info_val         = 1'b1;
        bus.info_src_ip      = info_q[0].sip;
        bus.info_dst_ip      = info_q[0].dip;
        bus.info_src_port    = info_q[0].sp;
        bus.info_dst_port    = info_q[0].dp;
        bus.info_data_length = info_q[0].len;
      end else begin
        bus.info_val = 1'b0;
      end
      if (pay_q.size() != 0) begin
        // an offered flit stays offered until taken
        if (!(bus.payload_val && seen_acc == pay_acc_cnt))
          bus.payload_val = ($urandom_range(0, 3) != 0);
        bus.payload_data = pay_q[0];
      end else begin
        bus.payload_val  = 1'b0;
        bus.payload_data = '0;
      end
      seen_acc = pay_acc_cnt;
    end
  end

  task automatic send(input int len, input int lit, input bit pin);
    info_t        f;
    logic [W-1:0] d;
    f.len       = 16'(len);
    f.lit_flits = lit;
    f.pin       = pin;
    if (pin) begin
      f.sip = 32'h0A000001;
      f.dip = 32'h0A000002;
      f.sp  = 16'd5000;
      f.dp  = 16'd7;
    end else begin
      f.sip = $urandom;
      f.dip = $urandom;
      f.sp  = 16'($urandom);
      f.dp  = 16'($urandom);
    end
    for (int i = 0; i < (len + BYTES - 1) / BYTES; i++) begin
      d = rand_flit();
      pay_q.push_back(d);
      exp_pay_q.push_back(d);
    end
    info_q.push_back(f);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (info_q.size() == 0 && sb_q.size() == 0 && pay_q.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL %s timeout act=busy exp=idle", nm);
  endtask

  initial begin
    int base;
    bit hit;
    repeat (3) @(negedge clk);
    chk("reset_noc_val", W'(bus.noc_val), W'(1'b0));
    chk("reset_noc_data", bus.noc_data, '0);
    chk("reset_info_rdy", W'(bus.info_rdy), W'(1'b1));
    chk("reset_payload_rdy", W'(bus.payload_rdy), W'(1'b0));
    rst_n = 1'b1;

    // directed lengths around the flit boundary
    send(100, 2, 1'b1);
    send(0, 0, 1'b0);
    send(64, 1, 1'b0);
    send(65, 2, 1'b0);
    wait_idle("directed");

    // stalls and back-to-back random datagrams
    stall_en = 1'b1;
    send(1000, 16, 1'b0);
    for (int k = 0; k < 6; k++) send(int'($urandom_range(0, 1500)), -1, 1'b0);
    wait_idle("random");

    // reset in the middle of a payload stream
    stall_en = 1'b0;
    base = pay_pops;
    hit  = 1'b0;
    send(512, 8, 1'b0);
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (pay_pops - base >= 3) hit = 1'b1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL mid_data_wait timeout act=%0d exp=3", pay_pops - base);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_noc_val", W'(bus.noc_val), W'(1'b0));
    chk("midrst_info_rdy", W'(bus.info_rdy), W'(1'b1));
    chk("midrst_payload_rdy", W'(bus.payload_rdy), W'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    stall_en = 1'b1;
    send(100, 2, 1'b1);
    send(200, 4, 1'b0);
    wait_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
